// File: rtl/fpu_mul_norm_shift_if.sv
// Handshake and data bundle between the product/LOPD stage (master) and the
// post-multiply normalizer (slave), plus the normalizer's result channel.
interface fpu_mul_norm_shift_if #(
    parameter int EXP_W = 8
);
    logic             i_valid;
    logic             o_ready;
    logic [15:0]      i_mant;
    logic [EXP_W-1:0] i_exp;
    logic [3:0]       i_lzc;
    logic             i_zero_flag;
    logic             o_valid;
    logic             i_ready;
    logic [15:0]      o_mant;
    logic [EXP_W-1:0] o_exp;
    logic             o_zero;
    logic             o_underflow;

    modport slave (
        input  i_valid, i_mant, i_exp, i_lzc, i_zero_flag, i_ready,
        output o_ready, o_valid, o_mant, o_exp, o_zero, o_underflow
    );

    modport master (
        output i_valid, i_mant, i_exp, i_lzc, i_zero_flag, i_ready,
        input  o_ready, o_valid, o_mant, o_exp, o_zero, o_underflow
    );
endinterface

// File: rtl/fpu_mul_norm_shift.sv
// Two-stage post-multiply normalizer: coarse nibble shift plus exponent
// subtract in stage A, fine shift and zero/underflow selection in stage B.
module fpu_mul_norm_shift #(
    parameter int EXP_W = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    fpu_mul_norm_shift_if.slave   bus
);
    logic             v_a_q;
    logic             v_b_q;
    logic             en_a;
    logic             en_b;

    logic [15:0]      mant_a_d;
    logic [15:0]      mant_a_q;
    logic [EXP_W:0]   diff_a_d;
    logic [EXP_W:0]   diff_a_q;
    logic [1:0]       fine_a_q;
    logic             zero_a_q;

    logic [15:0]      mant_d;
    logic [15:0]      mant_q;
    logic [EXP_W-1:0] exp_d;
    logic [EXP_W-1:0] exp_q;
    logic             zero_d;
    logic             zero_q;
    logic             uf_d;
    logic             uf_q;

    logic [15:0]      coarse_opt [4];
    logic [15:0]      fine_opt   [4];

    // Each stage moves only when the stage after it can take its contents.
    assign en_b        = !v_b_q || bus.i_ready;
    assign en_a        = !v_a_q || en_b;
    assign bus.o_ready = en_a;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_shift
            assign coarse_opt[gi] = bus.i_mant << (4 * gi);
            assign fine_opt[gi]   = mant_a_q << gi;
        end
    endgenerate

    assign mant_a_d = coarse_opt[bus.i_lzc[3:2]];
    // Signed in EXP_W+1 bits so that exponent underflow shows up in the MSB.
    assign diff_a_d = {1'b0, bus.i_exp} - {{(EXP_W - 3){1'b0}}, bus.i_lzc};

    always_comb begin
        mant_d = fine_opt[fine_a_q];
        exp_d  = diff_a_q[EXP_W-1:0];
        zero_d = 1'b0;
        uf_d   = 1'b0;
        if (zero_a_q) begin
            mant_d = '0;
            exp_d  = '0;
            zero_d = 1'b1;
        end else if (diff_a_q[EXP_W] || (diff_a_q == '0)) begin
            mant_d = '0;
            exp_d  = '0;
            zero_d = 1'b1;
            uf_d   = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v_a_q <= 1'b0;
            v_b_q <= 1'b0;
        end else begin
            if (en_a) v_a_q <= bus.i_valid;
            if (en_b) v_b_q <= v_a_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (en_a && bus.i_valid) begin
            mant_a_q <= mant_a_d;
            diff_a_q <= diff_a_d;
            fine_a_q <= bus.i_lzc[1:0];
            zero_a_q <= bus.i_zero_flag;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mant_q <= '0;
            exp_q  <= '0;
            zero_q <= 1'b0;
            uf_q   <= 1'b0;
        end else if (en_b && v_a_q) begin
            mant_q <= mant_d;
            exp_q  <= exp_d;
            zero_q <= zero_d;
            uf_q   <= uf_d;
        end
    end

    assign bus.o_valid     = v_b_q;
    assign bus.o_mant      = mant_q;
    assign bus.o_exp       = exp_q;
    assign bus.o_zero      = zero_q;
    assign bus.o_underflow = uf_q;
endmodule

// File: tb/tb_fpu_mul_norm_shift.sv
// Randomized and directed bench for fpu_mul_norm_shift; expected results come
// from an arithmetic model and an in-order scoreboard queue.
module tb_fpu_mul_norm_shift;
    localparam int EXP_W = 8;

    typedef struct {
        logic [15:0] mant;
        logic [7:0]  ex;
        logic        zero;
        logic        uf;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   lat_chk = 0;
    bit   stall_prev = 0;
    bit   ovr_en = 0;
    exp_t ovr;
    exp_t q[$];
    logic [15:0] hold_mant;
    logic [7:0]  hold_exp;
    logic        hold_zero;
    logic        hold_uf;

    fpu_mul_norm_shift_if #(.EXP_W(EXP_W)) bus ();

    fpu_mul_norm_shift #(.EXP_W(EXP_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Normalization by plain integer arithmetic: shift by lzc, subtract lzc.
    function automatic exp_t model(input logic [15:0] m, input logic [7:0] e,
                                   input logic [3:0] l, input logic z);
        exp_t r;
        int   d;
        r.cyc = 0;
        d = int'(e) - int'(l);
        if (z) begin
            r.mant = 16'h0; r.ex = 8'h0; r.zero = 1'b1; r.uf = 1'b0;
        end else if (d <= 0) begin
            r.mant = 16'h0; r.ex = 8'h0; r.zero = 1'b1; r.uf = 1'b1;
        end else begin
            r.mant = 16'((32'(m) << l) & 32'hFFFF);
            r.ex   = 8'(d);
            r.zero = 1'b0;
            r.uf   = 1'b0;
        end
        return r;
    endfunction

    task automatic drive_cycle(input logic v, input logic [15:0] m, input logic [7:0] e,
                               input logic [3:0] l, input logic z, input logic r,
                               output logic in_x);
        exp_t ent;
        @(negedge clk);
        bus.i_valid = v; bus.i_mant = m; bus.i_exp = e;
        bus.i_lzc = l; bus.i_zero_flag = z; bus.i_ready = r;
        #1;
        if (stall_prev) begin
            check("hold_valid", {31'b0, bus.o_valid}, 32'd1);
            check("hold_mant", {16'b0, bus.o_mant}, {16'b0, hold_mant});
            check("hold_exp", {24'b0, bus.o_exp}, {24'b0, hold_exp});
            check("hold_flags", {30'b0, bus.o_zero, bus.o_underflow}, {30'b0, hold_zero, hold_uf});
        end
        check("o_ready", {31'b0, bus.o_ready}, {31'b0, (q.size() < 2) || r});
        if (bus.o_valid && r) begin
            if (q.size() == 0) begin
                check("spurious_valid", {31'b0, bus.o_valid}, 32'd0);
            end else begin
                ent = q.pop_front();
                $display("[TB] out mant=%h exp=%0d zero=%0b uf=%0b", bus.o_mant, bus.o_exp,
                         bus.o_zero, bus.o_underflow);
                check("o_mant", {16'b0, bus.o_mant}, {16'b0, ent.mant});
                check("o_exp", {24'b0, bus.o_exp}, {24'b0, ent.ex});
                check("o_zero", {31'b0, bus.o_zero}, {31'b0, ent.zero});
                check("o_underflow", {31'b0, bus.o_underflow}, {31'b0, ent.uf});
                if (lat_chk) check("latency", 32'(cyc - ent.cyc), 32'd2);
            end
        end
        stall_prev = bus.o_valid && !r;
        hold_mant = bus.o_mant; hold_exp = bus.o_exp;
        hold_zero = bus.o_zero; hold_uf = bus.o_underflow;
        in_x = v && bus.o_ready;
        if (in_x) begin
            ent = ovr_en ? ovr : model(m, e, l, z);
            ent.cyc = cyc;
            q.push_back(ent);
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        logic x;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 16'h0, 8'h0, 4'h0, 1'b0, 1'b1, x);
    endtask

    task automatic drain();
        int n;
        logic x;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            drive_cycle(1'b0, 16'h0, 8'h0, 4'h0, 1'b0, 1'b1, x);
            n++;
        end
        check("drain_left", 32'(q.size()), 32'd0);
        q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; bus.i_valid = 1'b0; bus.i_ready = 1'b1;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_o_valid", {31'b0, bus.o_valid}, 32'd0);
        check("rst_o_mant", {16'b0, bus.o_mant}, 32'd0);
        check("rst_o_exp", {24'b0, bus.o_exp}, 32'd0);
        check("rst_flags", {30'b0, bus.o_zero, bus.o_underflow}, 32'd0);
        check("rst_o_ready", {31'b0, bus.o_ready}, 32'd1);
        q.delete();
        stall_prev = 0;
    endtask

    task automatic directed(input logic [15:0] m, input logic [7:0] e, input logic [3:0] l,
                            input logic z, input logic [15:0] wm, input logic [7:0] we,
                            input logic wz, input logic wu);
        logic x;
        ovr.mant = wm; ovr.ex = we; ovr.zero = wz; ovr.uf = wu; ovr.cyc = 0;
        ovr_en = 1;
        drive_cycle(1'b1, m, e, l, z, 1'b1, x);
        ovr_en = 0;
        check("directed_accept", {31'b0, x}, 32'd1);
        drain();
    endtask

    initial begin
        logic        x;
        logic [3:0]  l;
        logic [15:0] m;
        logic [7:0]  e;
        logic        z;
        logic [31:0] t;
        int          k;

        bus.i_valid = 0; bus.i_mant = 0; bus.i_exp = 0; bus.i_lzc = 0;
        bus.i_zero_flag = 0; bus.i_ready = 1;
        do_reset();

        lat_chk = 1;
        directed(16'h0001, 8'd20, 4'd15, 1'b0, 16'h8000, 8'd5, 1'b0, 1'b0);
        directed(16'h00A3, 8'd8, 4'd8, 1'b0, 16'h0000, 8'd0, 1'b1, 1'b1);
        directed(16'h00A3, 8'd9, 4'd8, 1'b0, 16'hA300, 8'd1, 1'b0, 1'b0);
        directed(16'h0000, 8'd100, 4'd0, 1'b1, 16'h0000, 8'd0, 1'b1, 1'b0);
        directed(16'h1234, 8'd2, 4'd3, 1'b0, 16'h0000, 8'd0, 1'b1, 1'b1);

        // Back-to-back stream with no backpressure.
        k = 0;
        for (int c = 0; c < 30 && (k < 6 || q.size() != 0); c++) begin
            drive_cycle(k < 6, 16'h8000 >> k, 8'd50, 4'(k), 1'b0, 1'b1, x);
            if (x) k++;
        end
        drain();

        // Same stream with the consumer stalled for cycles 3..7.
        lat_chk = 0;
        k = 0;
        for (int c = 0; c < 40 && (k < 6 || q.size() != 0); c++) begin
            drive_cycle(k < 6, 16'h8000 >> k, 8'd50, 4'(k), 1'b0, !(c >= 3 && c <= 7), x);
            if (x) k++;
        end
        check("stall_stream_sent", 32'(k), 32'd6);
        drain();

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            t = $urandom;
            l = 4'($urandom_range(0, 15));
            z = ($urandom_range(0, 15) == 0);
            if (z) begin
                m = 16'h0; l = 4'h0;
            end else if ($urandom_range(0, 7) == 0) begin
                m = t[15:0];
            end else begin
                m = (16'h8000 >> l) | (t[15:0] >> (l + 1));
            end
            e = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 255));
            drive_cycle($urandom_range(0, 3) != 0, m, e, l, z, $urandom_range(0, 3) != 0, x);
        end
        drain();

        // Reset with two beats in flight; nothing stale may emerge afterwards.
        drive_cycle(1'b1, 16'h0F00, 8'd60, 4'd4, 1'b0, 1'b0, x);
        drive_cycle(1'b1, 16'h00F0, 8'd60, 4'd8, 1'b0, 1'b0, x);
        do_reset();
        idle(6);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fpu_mul_norm_shift.md
# fpu_mul_norm_shift

Pipelined post-multiply normalizer for the FPU_MUL datapath: accepts a 16-bit unnormalized mantissa, its biased exponent and the leading-zero count/zero flag produced by the 16-bit leading-one detector, and left-shifts the mantissa so bit 15 is set while decrementing the exponent. It is the consumer side of the LOPD interface and sits between the mantissa product/LOPD stage and the rounding/pack stage. It is a 2-stage valid/ready pipeline with full backpressure, and it flushes to zero on exponent underflow.

## Interface
- EXP_W, 8, width of the biased exponent in and out
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  reset; synchronous, active-high
- i_valid  in  1  input beat valid
- o_ready  out  1  block can accept an input beat this cycle
- i_mant  in  16  unnormalized mantissa
- i_exp  in  EXP_W  biased exponent of i_mant (unsigned)
- i_lzc  in  4  leading-zero count of i_mant (0..15); 0 when i_zero_flag=1
- i_zero_flag  in  1  i_mant is all zeros
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream accepts output beat
- o_mant  out  16  normalized mantissa (bit 15 = 1 unless o_zero)
- o_exp  out  EXP_W  adjusted biased exponent
- o_zero  out  1  result is zero (zero input or underflow flush)
- o_underflow  out  1  result flushed because i_exp - i_lzc <= 0

## Operation
- Input transfer when i_valid && o_ready; output transfer when o_valid && i_ready.
- Stage A (captures on input transfer): mant_a = i_mant << (4*i_lzc[3:2]); diff_a = {1'b0,i_exp} - {0,i_lzc} computed in EXP_W+1 bits signed; holds i_lzc[1:0], i_zero_flag.
- Stage B: mant_b = mant_a << i_lzc[1:0]; result selection, priority order:
  - zero_flag=1: o_mant=0, o_exp=0, o_zero=1, o_underflow=0.
  - diff_a <= 0 (sign bit set or all zero): o_mant=0, o_exp=0, o_zero=1, o_underflow=1.
  - otherwise: o_mant=mant_b, o_exp=diff_a[EXP_W-1:0], o_zero=0, o_underflow=0.
- Shift always uses i_lzc as given; block does not re-check it against i_mant. Bits shifted out of bit 15 are discarded; zeros fill from bit 0.
- Stall logic: en_b = !v_b || i_ready; en_a = !v_a || en_b; o_ready = en_a. A stage advances only when its enable is high; otherwise its registers hold.
- o_valid = v_b. o_mant/o_exp/o_zero/o_underflow are registered outputs of stage B.

## Timing
- Latency: 2 cycles from input transfer to o_valid with i_ready held high.
- Throughput: 1 beat/cycle with i_ready=1; no bubbles.
- o_ready is combinational from i_ready and valid state (no path from i_valid/data).
- While o_valid=1 and i_ready=0, all outputs hold stable; stage A may still fill if empty; after both full, o_ready=0.
- Simultaneous output transfer and input transfer when full: both stages advance in the same cycle; no beat lost or duplicated.
- Reset: v_a=v_b=0, o_valid=0, o_mant=0, o_exp=0, o_zero=0, o_underflow=0; o_ready=1 in the first cycle after reset deasserts. Reset mid-operation discards all in-flight beats; no output beat after reset without a new input.
- Data registers need no reset beyond outputs above; valids always reset.

## Test plan
- i_mant=16'h0001, i_exp=20, i_lzc=15 -> two cycles later o_mant=16'h8000, o_exp=5, o_zero=0, o_underflow=0.
- i_mant=16'h00A3, i_exp=8, i_lzc=8 -> o_mant=16'hA300, o_exp=0 path check: diff=0 -> o_mant=0, o_exp=0, o_zero=1, o_underflow=1; same with i_exp=9 -> o_mant=16'hA300, o_exp=1.
- i_mant=0, i_zero_flag=1, i_lzc=0, i_exp=100 -> o_zero=1, o_underflow=0, o_mant=0, o_exp=0.
- Stream 6 beats (i_lzc=0..5 on i_mant=16'h8000>>k, i_exp=50) with i_ready=1 -> 6 consecutive outputs, all o_mant=16'h8000, o_exp=50-k, in order.
- Same stream with i_ready=0 for cycles 3-7 -> o_ready drops after 2 beats held; outputs stable while stalled; all 6 beats delivered in order, none duplicated.
- Assert i_rst for one cycle with 2 beats in flight -> o_valid=0 next cycle, all outputs 0, o_ready=1; no stale beat appears afterward.
